axi_ram_slave: RTL and testbench

Synthesizable AXI4 responder backed by a single-port RAM, sitting on the far side of a core cache port (icache or dcache) in place of a testbench memory model. Accepts AR/R and AW/W/B transactions from the core's 256-bit cache refill and writeback interface, serves one burst at a time, and returns OKAY, SLVERR or DECERR per burst. Used in FPGA and simulation tops as the core's main memory.

---
 rtl/axi_ram_slave.sv | 175 +++++++++++++++++
 tb/tb_axi_ram_slave.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// AXI4 responder in front of a single-port 256-bit RAM, one burst at a time.
// Define AXI_RAM_DECERR_EN to answer out-of-range beats with DECERR instead of wrapping the index.
module axi_ram_slave #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ar_valid,
  output logic         ar_ready,
  input  logic [63:0]  ar_payload_addr,
  input  logic [3:0]   ar_payload_id,
  input  logic [7:0]   ar_payload_len,
  input  logic [2:0]   ar_payload_size,
  input  logic [1:0]   ar_payload_burst,
  output logic         r_valid,
  input  logic         r_ready,
  output logic [255:0] r_payload_data,
  output logic [3:0]   r_payload_id,
  output logic [1:0]   r_payload_resp,
  output logic         r_payload_last,
  input  logic         aw_valid,
  output logic         aw_ready,
  input  logic [63:0]  aw_payload_addr,
  input  logic [3:0]   aw_payload_id,
  input  logic [7:0]   aw_payload_len,
  input  logic [2:0]   aw_payload_size,
  input  logic [1:0]   aw_payload_burst,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [255:0] w_payload_data,
  input  logic [31:0]  w_payload_strb,
  input  logic         w_payload_last,
  output logic         b_valid,
  input  logic         b_ready,
  output logic [3:0]   b_payload_id,
  output logic [1:0]   b_payload_resp
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, READ, WDATA, WRESP} state_t;

  state_t      st;
  logic        prefer_rd;
  logic [63:0] addr;
  logic [3:0]  id;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [8:0]  cnt;
  logic        slv, dec;

  logic [255:0] mem [DEPTH];

  logic [63:0]   widx, bsz, nxt;
  logic [AW-1:0] word;
  logic          oob, unsup, at_end, last_bad, issue, we;
  logic [1:0]    rresp, bresp;

  assign widx = (addr - BASE_ADDR) >> 5;
  assign word = AW'(widx % 64'(DEPTH));
`ifdef AXI_RAM_DECERR_EN
  assign oob  = (addr < BASE_ADDR) || (widx >= 64'(DEPTH));
`else
  assign oob  = 1'b0;
`endif
  // WRAP and the reserved encoding are both treated as unsupported
  assign unsup    = burst[1];
  assign bsz      = 64'd1 << size;
  assign nxt      = (burst == 2'd1) ? ((addr & ~(bsz - 64'd1)) + bsz) : addr;
  assign at_end   = (cnt == {1'b0, len});
  assign last_bad = (w_payload_last != at_end);
  assign issue    = (!r_valid || r_ready) && (cnt <= {1'b0, len});
  assign rresp    = oob ? 2'b11 : (unsup ? 2'b10 : 2'b00);
  assign bresp    = (dec || oob) ? 2'b11 : ((slv || last_bad || unsup) ? 2'b10 : 2'b00);
  assign we       = (st == WDATA) && w_valid && !reset && !unsup && !oob;

  assign ar_ready = !reset && (st == IDLE) && (!aw_valid || prefer_rd);
  assign aw_ready = !reset && (st == IDLE) && (!ar_valid || !prefer_rd);
  assign w_ready  = (st == WDATA);

  // RAM array has no reset so contents survive it
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 32; i++)
        if (w_payload_strb[i]) mem[word][i*8 +: 8] <= w_payload_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st             <= IDLE;
      prefer_rd      <= 1'b1;
      addr           <= '0;
      id             <= '0;
      len            <= '0;
      size           <= '0;
      burst          <= '0;
      cnt            <= '0;
      slv            <= 1'b0;
      dec            <= 1'b0;
      r_valid        <= 1'b0;
      r_payload_data <= '0;
      r_payload_id   <= '0;
      r_payload_resp <= '0;
      r_payload_last <= 1'b0;
      b_valid        <= 1'b0;
      b_payload_id   <= '0;
      b_payload_resp <= '0;
    end else begin
      case (st)
        IDLE: begin
          cnt <= '0;
          slv <= 1'b0;
          dec <= 1'b0;
          if (ar_valid && ar_ready) begin
            addr      <= ar_payload_addr;
            id        <= ar_payload_id;
            len       <= ar_payload_len;
            size      <= ar_payload_size;
            burst     <= ar_payload_burst;
            prefer_rd <= 1'b0;
            st        <= READ;
          end else if (aw_valid && aw_ready) begin
            addr      <= aw_payload_addr;
            id        <= aw_payload_id;
            len       <= aw_payload_len;
            size      <= aw_payload_size;
            burst     <= aw_payload_burst;
            prefer_rd <= 1'b1;
            st        <= WDATA;
          end
        end
        READ: begin
          if (r_valid && r_ready && r_payload_last) begin
            r_valid <= 1'b0;
            st      <= IDLE;
          end else if (issue) begin
            r_valid        <= 1'b1;
            r_payload_data <= oob ? '0 : mem[word];
            r_payload_resp <= rresp;
            r_payload_last <= at_end;
            r_payload_id   <= id;
            cnt            <= cnt + 9'd1;
            addr           <= nxt;
          end
        end
        WDATA: begin
          if (w_valid) begin
            cnt  <= cnt + 9'd1;
            addr <= nxt;
            if (last_bad) slv <= 1'b1;
            if (oob)      dec <= 1'b1;
            // the beat counter, not w_last, closes the burst
            if (at_end) begin
              st             <= WRESP;
              b_valid        <= 1'b1;
              b_payload_id   <= id;
              b_payload_resp <= bresp;
            end
          end
        end
        WRESP: begin
          if (b_ready) begin
            b_valid <= 1'b0;
            st      <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: reads, strobed writes, stalls, error bursts, arbitration, reset.
module tb_axi_ram_slave;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;

  logic         clk = 1'b0, reset = 1'b1;
  logic         ar_valid, ar_ready, r_valid, r_ready, r_payload_last;
  logic [63:0]  ar_payload_addr, aw_payload_addr;
  logic [3:0]   ar_payload_id, r_payload_id, aw_payload_id, b_payload_id;
  logic [7:0]   ar_payload_len, aw_payload_len;
  logic [2:0]   ar_payload_size, aw_payload_size;
  logic [1:0]   ar_payload_burst, aw_payload_burst, r_payload_resp, b_payload_resp;
  logic [255:0] r_payload_data, w_payload_data;
  logic         aw_valid, aw_ready, w_valid, w_ready, w_payload_last, b_valid, b_ready;
  logic [31:0]  w_payload_strb;

  axi_ram_slave dut (
    .clk(clk), .reset(reset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_payload_addr(ar_payload_addr),
    .ar_payload_id(ar_payload_id), .ar_payload_len(ar_payload_len),
    .ar_payload_size(ar_payload_size), .ar_payload_burst(ar_payload_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_payload_data(r_payload_data),
    .r_payload_id(r_payload_id), .r_payload_resp(r_payload_resp), .r_payload_last(r_payload_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_payload_addr(aw_payload_addr),
    .aw_payload_id(aw_payload_id), .aw_payload_len(aw_payload_len),
    .aw_payload_size(aw_payload_size), .aw_payload_burst(aw_payload_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_payload_data(w_payload_data),
    .w_payload_strb(w_payload_strb), .w_payload_last(w_payload_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_payload_id(b_payload_id), .b_payload_resp(b_payload_resp)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [255:0] model [16];
  logic [255:0] wd [16];
  logic [31:0]  ws [16];
  logic [255:0] rd_data [256];
  logic [1:0]   rd_resp [256];
  logic         rd_last [256];
  logic [3:0]   rd_id [256];
  int           rd_cyc [256];
  int           rd_n, rd_lat, bad, nl;
  logic [1:0]   b_got_resp;
  logic [3:0]   b_got_id;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h exp %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  // entered and left near a falling edge; inputs change only there
  task automatic read_burst(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input bit stall);
    int n, c;
    bit done, held;
    logic [255:0] hd;
    logic [3:0] rp;
    rp = 4'b1001;
    ar_payload_addr = a; ar_payload_id = id; ar_payload_len = len;
    ar_payload_size = 3'd5; ar_payload_burst = burst; ar_valid = 1'b1;
    rd_n = 0; rd_lat = -1;
    n = 0; #1;
    while (!ar_ready && n < 50) begin @(negedge clk); n++; #1; end
    if (!ar_ready) begin chk("ar_timeout", 0, 1); ar_valid = 1'b0; return; end
    @(negedge clk);
    ar_valid = 1'b0;
    c = 1; done = 0; held = 0; hd = '0;
    while (!done && c < 600) begin
      r_ready = stall ? rp[c % 4] : 1'b1;
      #1;
      if (held) begin
        chk("r_hold_data", r_payload_data, hd);
        chk("r_hold_valid", r_valid, 1);
      end
      if (r_valid && rd_lat < 0) rd_lat = c;
      if (r_valid && r_ready && rd_n < 256) begin
        rd_data[rd_n] = r_payload_data; rd_resp[rd_n] = r_payload_resp;
        rd_last[rd_n] = r_payload_last; rd_id[rd_n] = r_payload_id; rd_cyc[rd_n] = c;
        rd_n++;
        if (r_payload_last) done = 1;
      end
      held = r_valid && !r_ready;
      hd = r_payload_data;
      @(negedge clk);
      c++;
    end
    r_ready = 1'b0;
    if (!done) chk("rd_timeout", 0, 1);
  endtask

  task automatic write_burst(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input int bad_beat);
    int n;
    aw_payload_addr = a; aw_payload_id = id; aw_payload_len = len;
    aw_payload_size = 3'd5; aw_payload_burst = burst; aw_valid = 1'b1;
    b_got_resp = 2'bxx; b_got_id = 4'bxxxx;
    n = 0; #1;
    while (!aw_ready && n < 50) begin @(negedge clk); n++; #1; end
    if (!aw_ready) begin chk("aw_timeout", 0, 1); aw_valid = 1'b0; return; end
    @(negedge clk);
    aw_valid = 1'b0;
    #1 chk("w_ready_on", w_ready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1; w_payload_data = wd[i]; w_payload_strb = ws[i];
      w_payload_last = (i == int'(len)) ^ (i == bad_beat);
      #1 chk("b_early", b_valid, 0);
      @(negedge clk);
    end
    w_valid = 1'b0; w_payload_last = 1'b0;
    #1 chk("b_lat", b_valid, 1);
    b_got_resp = b_payload_resp; b_got_id = b_payload_id;
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    #1 chk("b_done", b_valid, 0);
  endtask

  initial begin
    ar_valid = 0; ar_payload_addr = '0; ar_payload_id = '0; ar_payload_len = '0;
    ar_payload_size = '0; ar_payload_burst = '0; r_ready = 0;
    aw_valid = 0; aw_payload_addr = '0; aw_payload_id = '0; aw_payload_len = '0;
    aw_payload_size = '0; aw_payload_burst = '0;
    w_valid = 0; w_payload_data = '0; w_payload_strb = '0; w_payload_last = 0; b_ready = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_data", r_payload_data, 0);
    chk("rst_r_last", r_payload_last, 0);
    chk("rst_b_resp", b_payload_resp, 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("ar_ready_post_rst", ar_ready, 1);

    // fill words 0..15
    for (int i = 0; i < 16; i++) begin wd[i] = pat(i); ws[i] = '1; model[i] = pat(i); end
    write_burst(BASE, 8'd15, 2'd1, 4'd3, -1);
    chk("fill_resp", b_got_resp, 0);
    chk("fill_id", b_got_id, 3);

    // strobed write: only bytes 0-3 of word 0, all of word 1
    wd[0] = {8{32'h1111_2222}}; ws[0] = 32'h0000_000F;
    wd[1] = {8{32'h5A5A_0001}}; ws[1] = '1;
    write_burst(BASE, 8'd1, 2'd1, 4'd4, -1);
    chk("strb_resp", b_got_resp, 0);
    model[0] = {model[0][255:32], 32'h1111_2222};
    model[1] = {8{32'h5A5A_0001}};

    read_burst(BASE + 64'h40, 8'd3, 2'd1, 4'd5, 0);
    chk("rd_lat", rd_lat, 2);
    chk("rd_n", rd_n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_data%0d", i), rd_data[i], model[2+i]);
      chk($sformatf("rd_last%0d", i), rd_last[i], (i == 3));
      chk($sformatf("rd_resp%0d", i), rd_resp[i], 0);
      chk($sformatf("rd_id%0d", i), rd_id[i], 5);
    end
    chk("rd_b2b", rd_cyc[3] - rd_cyc[0], 3);
    #1 chk("rd_turnaround", ar_ready, 1);

    read_burst(BASE, 8'd1, 2'd1, 4'd0, 0);
    chk("rb_word0", rd_data[0], model[0]);
    chk("rb_word1", rd_data[1], model[1]);

    // stalled read, words 1..8
    read_burst(BASE + 64'h20, 8'd7, 2'd1, 4'd6, 1);
    chk("stall_n", rd_n, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stall_data%0d", i), rd_data[i], model[1+i]);

    read_burst(BASE, 8'd3, 2'd2, 4'd7, 0);
    chk("wrap_rd_n", rd_n, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_rd_resp%0d", i), rd_resp[i], 2);

    wd[0] = '1; ws[0] = '1;
    write_burst(BASE + 64'h40, 8'd0, 2'd2, 4'd8, -1);
    chk("wrap_wr_resp", b_got_resp, 2);
    read_burst(BASE + 64'h40, 8'd0, 2'd1, 4'd8, 0);
    chk("wrap_wr_nochange", rd_data[0], model[2]);

    // early w_last: counter still ends the burst, both beats land
    wd[0] = pat(100); wd[1] = pat(101); ws[0] = '1; ws[1] = '1;
    write_burst(BASE + 64'h100, 8'd1, 2'd1, 4'd9, 0);
    chk("wlast_resp", b_got_resp, 2);
    chk("wlast_id", b_got_id, 9);
    model[8] = pat(100); model[9] = pat(101);
    read_burst(BASE + 64'h100, 8'd1, 2'd1, 4'd9, 0);
    chk("wlast_word8", rd_data[0], model[8]);
    chk("wlast_word9", rd_data[1], model[9]);

    // 256-beat FIXED burst on word 3
    read_burst(BASE + 64'h60, 8'd255, 2'd0, 4'd10, 0);
    bad = 0; nl = 0;
    for (int i = 0; i < rd_n; i++) begin
      if (rd_data[i] !== model[3]) bad++;
      if (rd_last[i]) nl++;
    end
    chk("fix_n", rd_n, 256);
    chk("fix_data_bad", bad, 0);
    chk("fix_nlast", nl, 1);
    chk("fix_last255", rd_last[255], 1);

    read_burst(BASE + 64'(DEPTH) * 64'd32, 8'd0, 2'd1, 4'd11, 0);
`ifdef AXI_RAM_DECERR_EN
    chk("oob_resp", rd_resp[0], 3);
    chk("oob_data", rd_data[0], 0);
    read_burst(BASE - 64'd32, 8'd0, 2'd1, 4'd11, 0);
    chk("below_resp", rd_resp[0], 3);
    chk("below_data", rd_data[0], 0);
    wd[0] = pat(55); ws[0] = '1;
    write_burst(BASE + 64'(DEPTH) * 64'd32, 8'd0, 2'd1, 4'd12, -1);
    chk("oob_wr_resp", b_got_resp, 3);
    read_burst(BASE, 8'd0, 2'd1, 4'd12, 0);
    chk("oob_wr_nochange", rd_data[0], model[0]);
`else
    chk("oob_resp", rd_resp[0], 0);
    chk("oob_wrap_data", rd_data[0], model[0]);
`endif

    // simultaneous AR/AW held through reset
    reset = 1'b1;
    ar_payload_addr = BASE + 64'h40; ar_payload_id = 4'd1; ar_payload_len = 8'd0;
    ar_payload_size = 3'd5; ar_payload_burst = 2'd1; ar_valid = 1'b1;
    aw_payload_addr = BASE + 64'h140; aw_payload_id = 4'd2; aw_payload_len = 8'd0;
    aw_payload_size = 3'd5; aw_payload_burst = 2'd1; aw_valid = 1'b1;
    wd[0] = pat(200); ws[0] = '1;
    #1;
    chk("cont_rst_ar", ar_ready, 0);
    chk("cont_rst_aw", aw_ready, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk("cont_ar_first", ar_ready, 1);
    chk("cont_aw_wait", aw_ready, 0);
    read_burst(BASE + 64'h40, 8'd0, 2'd1, 4'd1, 0);
    chk("cont_rd_data", rd_data[0], model[2]);
    chk("cont_rd_id", rd_id[0], 1);
    ar_payload_addr = BASE + 64'h60; ar_payload_id = 4'd4; ar_valid = 1'b1;
    #1;
    chk("alt_aw_next", aw_ready, 1);
    chk("alt_ar_wait", ar_ready, 0);
    write_burst(BASE + 64'h140, 8'd0, 2'd1, 4'd2, -1);
    chk("cont_wr_resp", b_got_resp, 0);
    chk("cont_wr_id", b_got_id, 2);
    model[10] = pat(200);
    aw_payload_addr = BASE + 64'h160; aw_payload_id = 4'd5; aw_valid = 1'b1;
    wd[0] = pat(201);
    #1;
    chk("alt2_ar_first", ar_ready, 1);
    chk("alt2_aw_wait", aw_ready, 0);
    read_burst(BASE + 64'h60, 8'd0, 2'd1, 4'd4, 0);
    chk("alt2_rd_data", rd_data[0], model[3]);
    write_burst(BASE + 64'h160, 8'd0, 2'd1, 4'd5, -1);
    model[11] = pat(201);
    read_burst(BASE + 64'h140, 8'd1, 2'd1, 4'd6, 0);
    chk("cont_word10", rd_data[0], model[10]);
    chk("cont_word11", rd_data[1], model[11]);

    // reset during beat 2 of an 8-beat write to words 12..19
    aw_payload_addr = BASE + 64'h180; aw_payload_id = 4'd6; aw_payload_len = 8'd7;
    aw_payload_size = 3'd5; aw_payload_burst = 2'd1; aw_valid = 1'b1;
    #1;
    chk("mid_aw_ready", aw_ready, 1);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_valid = 1'b1; w_payload_data = pat(50 + i); w_payload_strb = '1; w_payload_last = 1'b0;
      @(negedge clk);
    end
    w_payload_data = pat(52);
    reset = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    chk("mid_w_ready", w_ready, 0);
    chk("mid_b_valid", b_valid, 0);
    chk("mid_r_valid", r_valid, 0);
    chk("mid_ar_ready", ar_ready, 0);
    chk("mid_aw_ready_rst", aw_ready, 0);
    chk("mid_r_data", r_payload_data, 0);
    chk("mid_b_id", b_payload_id, 0);
    @(negedge clk);
    reset = 1'b0;
    model[12] = pat(50); model[13] = pat(51);
    #1 chk("mid_ar_after", ar_ready, 1);
    read_burst(BASE + 64'h180, 8'd2, 2'd1, 4'd7, 0);
    chk("mid_word12", rd_data[0], model[12]);
    chk("mid_word13", rd_data[1], model[13]);
    chk("mid_word14", rd_data[2], model[14]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
